// File: rtl/scan_bist_ctrl.sv
// scan_bist_ctrl: LFSR pattern source and MISR response compactor with a golden-signature check.
module scan_bist_ctrl #(
  parameter int WIDTH = 8,
  parameter int NUM_PAT = 16,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] GOLDEN = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cut_resp,
  output logic [WIDTH-1:0] pat_out,
  output logic             bist_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);
  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, sig_q, sig_d, pat_q, pat_d;
  logic [WIDTH-1:0] lfsr_step, sig_step;
  logic [15:0] cnt_q, cnt_d;
  logic done_q, done_d, pass_q, pass_d;
  assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign sig_step  = {sig_q[WIDTH-2:0], ^(sig_q & TAPS)} ^ cut_resp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      sig_q   <= '0;
      pat_q   <= SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_d = RUN;
          lfsr_d  = SEED;
          sig_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
        RUN: begin
          // a tap mask without the MSB can shift into zero; reseed rather than lock up
          lfsr_d  = (lfsr_step == '0) ? SEED : lfsr_step;
          sig_d   = sig_step;
          pat_d   = lfsr_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_q == 16'(NUM_PAT - 1)) ? COMPARE : RUN;
        end
        COMPARE: begin
          pass_d  = (sig_q == GOLDEN);
          done_d  = 1'b1;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // outside RUN the last retired pattern stays on pat_out
  assign bist_en   = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == COMPARE);
  assign pat_out   = bist_en ? lfsr_q : pat_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
endmodule

// File: tb/tb_scan_bist_ctrl.sv
// tb_scan_bist_ctrl: directed scenarios, per-cycle model comparison and literal pins.
module tb_scan_bist_ctrl;
  localparam int N = 4;
  localparam logic [3:0] SEED = 4'b0001, TAPS = 4'b1100, GOLDEN = 4'b0000;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, mode = 1'b0, chk_en = 1'b0;
  logic [3:0] cut_resp, pat_out, signature;
  logic bist_en, busy, done, pass;
  int tests = 0, fails = 0;
  logic [3:0] rec_pat [4];
  logic [3:0] rec_sig [4];
  int bcnt, dfirst;

  always #5 clk = ~clk;
  assign cut_resp = mode ? (pat_out | 4'b0001) : pat_out;

  scan_bist_ctrl #(.WIDTH(4), .NUM_PAT(N), .SEED(SEED), .TAPS(TAPS), .GOLDEN(GOLDEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cut_resp(cut_resp),
    .pat_out(pat_out), .bist_en(bist_en), .busy(busy), .done(done), .pass(pass),
    .signature(signature)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] shift_fb(input logic [3:0] r);
    int v;
    v = int'(r) * 2 + ($countones(r & TAPS) % 2);
    return 4'(v % 16);
  endfunction

  function automatic logic [3:0] lfsr_next(input logic [3:0] r);
    return (shift_fb(r) == 4'd0) ? SEED : shift_fb(r);
  endfunction

  // model: pos = -1 idle, 0..N-1 applying pattern pos, N comparing, N+1 finished
  int pos;
  logic [3:0] m_lfsr, m_sig, m_pat;
  logic m_done, m_pass;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= -1; m_lfsr <= SEED; m_sig <= 4'd0; m_pat <= SEED; m_done <= 1'b0; m_pass <= 1'b0;
    end else if (abort) begin
      pos <= -1; m_done <= 1'b0; m_pass <= 1'b0;
    end else if ((pos < 0 || pos > N) && start) begin
      pos <= 0; m_lfsr <= SEED; m_sig <= 4'd0; m_done <= 1'b0; m_pass <= 1'b0;
    end else if (pos >= 0 && pos < N) begin
      m_pat <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
      m_sig <= shift_fb(m_sig) ^ (mode ? (m_lfsr | 4'b0001) : m_lfsr);
      pos <= pos + 1;
    end else if (pos == N) begin
      m_done <= 1'b1; m_pass <= (m_sig == GOLDEN); pos <= N + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_bist_en", 32'(bist_en), 32'(pos >= 0 && pos < N));
      check("cyc_busy", 32'(busy), 32'(pos >= 0 && pos <= N));
      check("cyc_pat_out", 32'(pat_out), 32'((pos >= 0 && pos < N) ? m_lfsr : m_pat));
      check("cyc_signature", 32'(signature), 32'(m_sig));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_pass", 32'(pass), 32'(m_pass));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_and_record();
    start = 1'b1;
    step();
    start = 1'b0;
    bcnt = 0;
    dfirst = -1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) rec_pat[k] = pat_out;
      if (k >= 1 && k <= 4) rec_sig[k-1] = signature;
      if (busy) bcnt++;
      if (done && dfirst < 0) dfirst = k;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_pat_out", 32'(pat_out), 32'h1);
    check("rst_signature", 32'(signature), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bist_en", 32'(bist_en), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    chk_en = 1'b1;
    #9 rst_n = 1'b1;
    mode = 1'b0;
    run_and_record();
    check("seq_pat0", 32'(rec_pat[0]), 32'h1);
    check("seq_pat1", 32'(rec_pat[1]), 32'h2);
    check("seq_pat2", 32'(rec_pat[2]), 32'h4);
    check("seq_pat3", 32'(rec_pat[3]), 32'h9);
    check("seq_busy_cycles", 32'(bcnt), 32'd5);
    check("seq_done_edge", 32'(dfirst), 32'd5);
    check("loop_signature", 32'(signature), 32'h0);
    check("loop_pass", 32'(pass), 32'h1);
    check("loop_pat_hold", 32'(pat_out), 32'h9);
    mode = 1'b1;
    run_and_record();
    check("sa1_sig1", 32'(rec_sig[0]), 32'h1);
    check("sa1_sig2", 32'(rec_sig[1]), 32'h1);
    check("sa1_sig3", 32'(rec_sig[2]), 32'h7);
    check("sa1_sig4", 32'(rec_sig[3]), 32'h6);
    check("sa1_pass", 32'(pass), 32'h0);
    check("sa1_done", 32'(done), 32'h1);
    mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_sig_hold", 32'(signature), 32'h1);
    run_and_record();
    check("abort_rerun_pat0", 32'(rec_pat[0]), 32'h1);
    check("abort_rerun_pass", 32'(pass), 32'h1);
    mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    check("midrst_pat_out", 32'(pat_out), 32'h1);
    check("midrst_signature", 32'(signature), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_bist_en", 32'(bist_en), 32'h0);
    check("midrst_done_pass", 32'({done, pass}), 32'h0);
    #1 rst_n = 1'b1;
    step();
    step();
    check("midrst_idle", 32'(busy), 32'h0);
    mode = 1'b0;
    bcnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bist_en) bcnt++;
      if (k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
      step();
    end
    check("ignore_start_captures", 32'(bcnt), 32'd4);
    check("ignore_start_done", 32'(done), 32'h1);
    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scan_bist_ctrl.md
SCAN_BIST_CTRL -- requirements
Module: scan_bist_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pattern, response and signature width; legal range 2..32.
REQ-002 SHALL have parameter NUM_PAT, default 16: patterns applied per run; legal range 1..65535.
REQ-003 SHALL have parameter SEED, default {WIDTH{1'b0}} | 1: LFSR load value; must be non-zero.
REQ-004 SHALL have parameter TAPS, default 8'hB8: feedback tap mask shared by the LFSR and the MISR.
REQ-005 SHALL have parameter GOLDEN, default 0: expected final signature.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have port start, input, 1 bit: begin a run, sampled high for one cycle.
REQ-009 SHALL have port abort, input, 1 bit: cancel a run and return to idle.
REQ-010 SHALL have port cut_resp, input, WIDTH bits: circuit-under-test response.
REQ-011 SHALL have port pat_out, output, WIDTH bits: current test pattern.
REQ-012 SHALL have port bist_en, output, 1 bit: selects pat_out into the circuit under test.
REQ-013 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-014 SHALL have port done, output, 1 bit: run complete, result valid.
REQ-015 SHALL have port pass, output, 1 bit: signature == GOLDEN; qualified by done.
REQ-016 SHALL have port signature, output, WIDTH bits: current MISR contents.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, COMPARE, DONE.
REQ-018 IDLE or DONE with start=1: on that edge, load lfsr=SEED, sig=0 and cnt=0, clear done and pass, and enter RUN.
REQ-019 RUN behaviour:
- bist_en=1 and pat_out=lfsr.
- On each edge: sig <= {sig[WIDTH-2:0], ^(sig&TAPS)} ^ cut_resp.
- On each edge: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr&TAPS)}.
- On each edge: cnt <= cnt+1.
REQ-020 The response SHALL be captured on the same edge the pattern is retired, because the circuit under test is combinational between pat_out and cut_resp.
REQ-021 RUN SHALL go to COMPARE on the edge that captures pattern NUM_PAT-1. Exactly NUM_PAT captures occur per run.
REQ-022 COMPARE lasts one cycle: pass <= (sig==GOLDEN), done <= 1, then go to DONE.
REQ-023 DONE SHALL hold done, pass, signature and pat_out until start or abort.
REQ-024 busy SHALL be 1 in RUN and COMPARE only, so it is high for NUM_PAT+1 cycles per run.
REQ-025 bist_en SHALL be 1 in RUN only. In other states pat_out holds its last value.
REQ-026 start SHALL be ignored while in RUN or COMPARE.
REQ-027 abort SHALL take priority over start. On abort, in any state, on the next edge:
- Go to IDLE.
- Clear done and pass; busy falls.
- Leave signature and lfsr unchanged.
REQ-028 cnt SHALL be 16 bits wide; it must not wrap within a run.
REQ-029 The LFSR SHALL never hold zero when SEED is non-zero.
REQ-030 NUM_PAT=1 SHALL give one RUN cycle followed by COMPARE.

Reset
REQ-031 While rst_n=0, immediately and without waiting for a clock edge:
- state=IDLE.
- pat_out=SEED, lfsr=SEED.
- signature=0, cnt=0.
- bist_en=0, busy=0, done=0, pass=0.
REQ-032 Asserting rst_n mid-run SHALL discard the run. After release the block waits in IDLE for start.
REQ-033 Release of rst_n SHALL be synchronous to clk. The first start is honoured on the first edge after release.

Verification
All scenarios use WIDTH=4, TAPS=4'b1100, SEED=4'b0001, NUM_PAT=4, GOLDEN=4'b0000.
REQ-034 Sequence: start pulse -> pat_out over RUN is 0001, 0010, 0100, 1001; busy is high for 5 cycles; done=1 at the 6th edge after start.
REQ-035 Loopback (cut_resp=pat_out) -> signature=0000 and pass=1 in DONE.
REQ-036 Stuck-at-1 on cut_resp[0] (cut_resp=pat_out|0001):
- Signature steps through 0001, 0001, 0111, 0110.
- Final state: pass=0, done=1.
REQ-037 abort asserted in the 2nd RUN cycle -> busy=0 and done=0 next cycle; a following start reruns from pat_out=0001.
REQ-038 Two cases, one check each:
- Reset mid-RUN: rst_n low for 3 ns between edges -> all outputs reach reset values before the next edge.
- Busy ignores start: start pulsed during RUN -> the run still ends after exactly 4 captures.
